// File: rtl/systolic_grid_ctrl.sv
// systolic_grid_ctrl: sequencer for one TILE x TILE systolic MAC grid.
// Phases: FEED skewed operand columns, FLUSH the skew and PE pipeline with
// zero operands, then DRAIN TILE rows of C under output backpressure.
// Optional stall counters are compiled in with `define SYSTOLIC_CTRL_PERF_EN.
module systolic_grid_ctrl #(
  parameter int TILE   = 32,
  parameter int PE_LAT = 2,
  parameter int K_BITS = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [K_BITS-1:0] kLen,
  input  logic              feedValid,
  output logic              feedReady,
  output logic              zeroFeed,
  output logic              enableMul,
  output logic              enableShiftOut,
  output logic              outValid,
  input  logic              outReady,
  output logic              busy,
  output logic              done,
  output logic              badStart
`ifdef SYSTOLIC_CTRL_PERF_EN
  ,
  output logic [31:0]       feedStallCycles,
  output logic [31:0]       drainStallCycles
`endif
);

  // Zero-operand cycles needed to push the last column through the skew
  // and the PE accumulate pipeline.
  localparam int FLUSH_LEN = TILE - 1 + PE_LAT;
  localparam int F_W       = $clog2(TILE + PE_LAT);
  localparam int R_W       = (TILE > 1) ? $clog2(TILE) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FEED,
    S_FLUSH,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t            state_q;
  logic [K_BITS-1:0] k_len_q;
  logic [K_BITS-1:0] k_cnt_q;
  logic [F_W-1:0]    f_cnt_q;
  logic [R_W-1:0]    r_cnt_q;
  logic              bad_start_q;

  logic start_accept;
  logic col_accept;
  logic row_shift;

  assign start_accept = (state_q == S_IDLE) && start && (kLen != '0);
  assign col_accept   = (state_q == S_FEED) && feedValid;
  assign row_shift    = (state_q == S_DRAIN) && outReady;

  // Sequencer state and phase counters; terminal counts are tested before
  // incrementing so no counter ever wraps.
  // NOTE: all state here uses non-blocking assignments so every register
  // samples pre-edge values; blocking would create order-dependent races.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      k_len_q     <= '0;
      k_cnt_q     <= '0;
      f_cnt_q     <= '0;
      r_cnt_q     <= '0;
      bad_start_q <= 1'b0;
    end else begin
      bad_start_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (start_accept) begin
            k_len_q <= kLen;
            k_cnt_q <= '0;
            state_q <= S_FEED;
          end else if (start) begin
            bad_start_q <= 1'b1;
          end
        end
        S_FEED: begin
          if (col_accept) begin
            if (k_cnt_q == k_len_q - K_BITS'(1)) begin
              f_cnt_q <= '0;
              state_q <= S_FLUSH;
            end else begin
              k_cnt_q <= k_cnt_q + K_BITS'(1);
            end
          end
        end
        S_FLUSH: begin
          if (f_cnt_q == F_W'(FLUSH_LEN - 1)) begin
            r_cnt_q <= '0;
            state_q <= S_DRAIN;
          end else begin
            f_cnt_q <= f_cnt_q + F_W'(1);
          end
        end
        S_DRAIN: begin
          if (row_shift) begin
            if (r_cnt_q == R_W'(TILE - 1)) begin
              state_q <= S_DONE;
            end else begin
              r_cnt_q <= r_cnt_q + R_W'(1);
            end
          end
        end
        S_DONE: state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Outputs decode the state register; only the handshake-qualified enables
  // look at feedValid/outReady, and FEED/DRAIN are disjoint so enableMul and
  // enableShiftOut can never be high together.
  assign feedReady      = (state_q == S_FEED);
  assign zeroFeed       = (state_q == S_FLUSH);
  assign enableMul      = col_accept || (state_q == S_FLUSH);
  assign enableShiftOut = row_shift;
  assign outValid       = (state_q == S_DRAIN);
  assign busy           = (state_q != S_IDLE);
  assign done           = (state_q == S_DONE);
  assign badStart       = bad_start_q;

`ifdef SYSTOLIC_CTRL_PERF_EN
  logic [31:0] feed_stall_q;
  logic [31:0] drain_stall_q;

  // Saturating stall counters, cleared when a new tile is accepted.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      feed_stall_q  <= '0;
      drain_stall_q <= '0;
    end else if (start_accept) begin
      feed_stall_q  <= '0;
      drain_stall_q <= '0;
    end else begin
      if ((state_q == S_FEED) && !feedValid && (feed_stall_q != '1))
        feed_stall_q <= feed_stall_q + 32'd1;
      if ((state_q == S_DRAIN) && !outReady && (drain_stall_q != '1))
        drain_stall_q <= drain_stall_q + 32'd1;
    end
  end

  assign feedStallCycles  = feed_stall_q;
  assign drainStallCycles = drain_stall_q;
`endif

endmodule

// File: tb/tb_systolic_grid_ctrl.sv
// Bench for systolic_grid_ctrl (TILE=4, PE_LAT=2). Each scenario is expanded
// into per-cycle stimulus and expected-output queues from its phase plan;
// the run loop pops one of each per cycle and compares.
module tb_systolic_grid_ctrl;

  localparam int TILE   = 4;
  localparam int PE_LAT = 2;
  localparam int K_BITS = 16;

  logic              clock;
  logic              reset;
  logic              start;
  logic [K_BITS-1:0] kLen;
  logic              feedValid;
  logic              feedReady;
  logic              zeroFeed;
  logic              enableMul;
  logic              enableShiftOut;
  logic              outValid;
  logic              outReady;
  logic              busy;
  logic              done;
  logic              badStart;
`ifdef SYSTOLIC_CTRL_PERF_EN
  logic [31:0]       feedStallCycles;
  logic [31:0]       drainStallCycles;
`endif

  systolic_grid_ctrl #(.TILE(TILE), .PE_LAT(PE_LAT), .K_BITS(K_BITS)) dut (
    .clock          (clock),
    .reset          (reset),
    .start          (start),
    .kLen           (kLen),
    .feedValid      (feedValid),
    .feedReady      (feedReady),
    .zeroFeed       (zeroFeed),
    .enableMul      (enableMul),
    .enableShiftOut (enableShiftOut),
    .outValid       (outValid),
    .outReady       (outReady),
    .busy           (busy),
    .done           (done),
    .badStart       (badStart)
`ifdef SYSTOLIC_CTRL_PERF_EN
    ,
    .feedStallCycles  (feedStallCycles),
    .drainStallCycles (drainStallCycles)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    logic              start;
    logic [K_BITS-1:0] k_len;
    logic              fv;
    logic              ordy;
  } stim_t;

  // Expected vector order:
  // {feedReady, zeroFeed, enableMul, enableShiftOut, outValid, busy, done, badStart}
  stim_t      stim_q[$];
  logic [7:0] exp_q[$];
  int         n_checks = 0;
  int         n_errors = 0;
  int         cyc      = 0;

  function automatic logic [7:0] outs();
    return {feedReady, zeroFeed, enableMul, enableShiftOut,
            outValid, busy, done, badStart};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic push(input logic st, input int k, input logic fv, input logic r,
                      input logic [7:0] e);
    stim_t s;
    s.start = st;
    s.k_len = K_BITS'(k);
    s.fv    = fv;
    s.ordy  = r;
    stim_q.push_back(s);
    exp_q.push_back(e);
  endtask

  // One tile from its phase plan: start cycle, FEED until k columns are
  // accepted, TILE-1+PE_LAT flush cycles, DRAIN until TILE shifts, DONE, IDLE.
  // Patterns give feedValid/outReady per cycle of their phase (1 once exhausted).
  task automatic gen_tile(input int k, input logic [31:0] fv_pat, input int fv_len,
                          input logic [31:0] or_pat, input int or_len,
                          input int start_in_drain_at);
    int   acc;
    int   idx;
    int   sh;
    logic b;
    push(1'b1, k, 1'b0, 1'b0, 8'b0000_0000);
    acc = 0;
    idx = 0;
    while (acc < k) begin
      b = (idx < fv_len) ? fv_pat[idx] : 1'b1;
      push(1'b0, 0, b, 1'b0, {1'b1, 1'b0, b, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0});
      if (b) acc++;
      idx++;
    end
    for (int i = 0; i < TILE - 1 + PE_LAT; i++)
      push(1'b0, 0, 1'b0, 1'b0, 8'b0110_0100);
    sh  = 0;
    idx = 0;
    while (sh < TILE) begin
      b = (idx < or_len) ? or_pat[idx] : 1'b1;
      push(idx == start_in_drain_at, 3, 1'b0, b,
           {1'b0, 1'b0, 1'b0, b, 1'b1, 1'b1, 1'b0, 1'b0});
      if (b) sh++;
      idx++;
    end
    push(1'b0, 0, 1'b0, 1'b0, 8'b0000_0110);
    push(1'b0, 0, 1'b0, 1'b0, 8'b0000_0000);
  endtask

  // Drive up to n queued cycles: inputs on the falling edge, compare 1 ns later.
  task automatic run_cycles(input int n);
    stim_t      s;
    logic [7:0] e;
    for (int i = 0; i < n && stim_q.size() > 0; i++) begin
      s = stim_q.pop_front();
      e = exp_q.pop_front();
      @(negedge clock);
      start     = s.start;
      kLen      = s.k_len;
      feedValid = s.fv;
      outReady  = s.ordy;
      #1;
      check($sformatf("cycle%0d", cyc), {24'd0, outs()}, {24'd0, e});
      cyc++;
    end
  endtask

  initial begin
    reset     = 1'b0;
    start     = 1'b0;
    kLen      = '0;
    feedValid = 1'b0;
    outReady  = 1'b0;
    #12;
    check("reset_outputs", {24'd0, outs()}, 32'd0);
`ifdef SYSTOLIC_CTRL_PERF_EN
    check("reset_feed_stall", feedStallCycles, 32'd0);
    check("reset_drain_stall", drainStallCycles, 32'd0);
`endif
    @(negedge clock);
    reset = 1'b1;

    // Nominal tile: kLen=3, no stalls -> FEED 1-3, FLUSH 4-8, DRAIN 9-12, done 13.
    cyc = 0;
    gen_tile(3, 32'd0, 0, 32'd0, 0, -1);
    run_cycles(1000);

    // Shortest reduction.
    cyc = 0;
    gen_tile(1, 32'd0, 0, 32'd0, 0, -1);
    run_cycles(1000);

    // kLen=5 with a 4-cycle feedValid gap (FEED lasts 9 cycles); outReady
    // pattern 1,0,0,1,0,1,1 gives 4 shifts and 3 stalls; start during DRAIN ignored.
    cyc = 0;
    gen_tile(5, 32'h0000_01C3, 9, 32'h0000_0069, 7, 1);
    run_cycles(1000);
    for (int i = 0; i < 3; i++) push(1'b0, 0, 1'b0, 1'b0, 8'b0000_0000);
    run_cycles(1000);
`ifdef SYSTOLIC_CTRL_PERF_EN
    check("feed_stall_count", feedStallCycles, 32'd4);
    check("drain_stall_count", drainStallCycles, 32'd3);
    cyc = 0;
    gen_tile(2, 32'd0, 0, 32'd0, 0, -1);
    run_cycles(2);
    check("feed_stall_cleared", feedStallCycles, 32'd0);
    check("drain_stall_cleared", drainStallCycles, 32'd0);
    run_cycles(1000);
`endif

    // Zero-length start: badStart pulses once, never busy.
    cyc = 0;
    push(1'b1, 0, 1'b0, 1'b0, 8'b0000_0000);
    push(1'b0, 0, 1'b0, 1'b0, 8'b0000_0001);
    push(1'b0, 0, 1'b0, 1'b0, 8'b0000_0000);
    run_cycles(1000);

    // Reset asserted in FLUSH clears every output immediately.
    cyc = 0;
    gen_tile(2, 32'd0, 0, 32'd0, 0, -1);
    run_cycles(5);
    check("in_flush_before_reset", {31'd0, zeroFeed}, 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check("async_reset_outputs", {24'd0, outs()}, 32'd0);
    stim_q.delete();
    exp_q.delete();
    @(negedge clock);
    reset = 1'b1;

    // Fresh kLen=2 tile after reset has the full normal timeline.
    cyc = 0;
    gen_tile(2, 32'd0, 0, 32'd0, 0, -1);
    run_cycles(1000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
